// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared BE control-pipe types.
// Holds the fu op encoding and the control-pipe stage payload.
`ifndef BP_BE_VADDR_W
`define BP_BE_VADDR_W 39
`endif

package bp_be_pkg;

  localparam int vaddr_width_gp = `BP_BE_VADDR_W;

  typedef enum logic [3:0] {
    e_ctrl_op_beq  = 4'd0,
    e_ctrl_op_bne  = 4'd1,
    e_ctrl_op_blt  = 4'd2,
    e_ctrl_op_bge  = 4'd3,
    e_ctrl_op_bltu = 4'd4,
    e_ctrl_op_bgeu = 4'd5,
    e_ctrl_op_jalr = 4'd6,
    e_ctrl_op_jal  = 4'd7
  } bp_be_ctrl_fu_op_e;

  typedef struct packed {
    logic                      v;
    logic                      queue_v;
    logic                      ctl_v;
    logic                      btaken;
    logic [vaddr_width_gp-1:0] npc;
    logic [vaddr_width_gp-1:0] ntaken_tgt;
    logic [vaddr_width_gp-1:0] pred_npc;
  } bp_be_ctl_stage_s;

endpackage

// File: rtl/bp_be_pipe_ctl_pipelined_if.sv
// bp_be_pipe_ctl_pipelined_if: issue bundle in, branch packet out.
// master drives the op, slave is the control pipe.
interface bp_be_pipe_ctl_pipelined_if #(
  parameter int vaddr_width_p = 39,
  parameter int dword_width_p = 64,
  parameter int dpath_width_p = 66,
  parameter int cnt_width_p   = 16
);
  import bp_be_pkg::*;

  logic                     v_i;
  logic                     queue_v_i;
  bp_be_ctrl_fu_op_e        fu_op_i;
  logic                     baddr_sel_i;
  logic [vaddr_width_p-1:0] pc_i;
  logic [dword_width_p-1:0] rs1_i;
  logic [dword_width_p-1:0] rs2_i;
  logic [dword_width_p-1:0] imm_i;
  logic [vaddr_width_p-1:0] pred_npc_i;
  logic                     flush_i;
  logic                     clr_cnt_i;

  logic                     v_o;
  logic [dpath_width_p-1:0] data_o;
  logic                     br_v_o;
  logic                     btaken_o;
  logic [vaddr_width_p-1:0] npc_o;
  logic                     mispredict_o;
  logic [cnt_width_p-1:0]   mispredict_cnt_o;

  modport master (
    output v_i, queue_v_i, fu_op_i, baddr_sel_i,
    output pc_i, rs1_i, rs2_i, imm_i, pred_npc_i,
    output flush_i, clr_cnt_i,
    input  v_o, data_o, br_v_o, btaken_o,
    input  npc_o, mispredict_o, mispredict_cnt_o
  );

  modport slave (
    input  v_i, queue_v_i, fu_op_i, baddr_sel_i,
    input  pc_i, rs1_i, rs2_i, imm_i, pred_npc_i,
    input  flush_i, clr_cnt_i,
    output v_o, data_o, br_v_o, btaken_o,
    output npc_o, mispredict_o, mispredict_cnt_o
  );

endinterface

// File: rtl/bp_be_ctl_resolve.sv
// bp_be_ctl_resolve: stage-0 branch compare and target generation.
// Purely combinational; feeds the first payload register.
module bp_be_ctl_resolve
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp,
  parameter int dword_width_p = 64
) (
  input  bp_be_ctrl_fu_op_e        fu_op_i,
  input  logic                     baddr_sel_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] rs2_i,
  input  logic [dword_width_p-1:0] imm_i,
  output logic                     ctl_v_o,
  output logic                     btaken_o,
  output logic [vaddr_width_p-1:0] npc_o,
  output logic [vaddr_width_p-1:0] ntaken_tgt_o
);

  logic                     eq;
  logic                     slt;
  logic                     ult;
  logic [vaddr_width_p-1:0] base;
  logic [vaddr_width_p-1:0] sum;
  logic                     unused_bits;

  assign eq   = (rs1_i == rs2_i);
  assign slt  = ($signed(rs1_i) < $signed(rs2_i));
  assign ult  = (rs1_i < rs2_i);
  assign base = baddr_sel_i ? rs1_i[vaddr_width_p-1:0] : pc_i;
  assign sum  = base + imm_i[vaddr_width_p-1:0];

  assign ntaken_tgt_o = pc_i + vaddr_width_p'(4);
  assign unused_bits  = ^{imm_i[dword_width_p-1:vaddr_width_p], sum[0]};

  always_comb begin
    ctl_v_o  = 1'b1;
    btaken_o = 1'b0;
    unique case (1'b1)
      (fu_op_i == e_ctrl_op_beq):  btaken_o = eq;
      (fu_op_i == e_ctrl_op_bne):  btaken_o = ~eq;
      (fu_op_i == e_ctrl_op_blt):  btaken_o = slt;
      (fu_op_i == e_ctrl_op_bge):  btaken_o = ~slt;
      (fu_op_i == e_ctrl_op_bltu): btaken_o = ult;
      (fu_op_i == e_ctrl_op_bgeu): btaken_o = ~ult;
      (fu_op_i == e_ctrl_op_jalr): btaken_o = 1'b1;
      (fu_op_i == e_ctrl_op_jal):  btaken_o = 1'b1;
      default:                     ctl_v_o  = 1'b0;
    endcase
  end

  assign npc_o = btaken_o
               ? {sum[vaddr_width_p-1:1], 1'b0}
               : ntaken_tgt_o;

endmodule

// File: rtl/bp_be_pipe_ctl_pipelined.sv
// bp_be_pipe_ctl_pipelined: branch/jal/jalr resolution over latency_p
// register stages, with mispredict detect and saturating counter.
module bp_be_pipe_ctl_pipelined
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp,
  parameter int dword_width_p = 64,
  parameter int dpath_width_p = 66,
  parameter int latency_p     = 2,
  parameter int cnt_width_p   = 16
) (
  input logic                           clk_i,
  input logic                           reset_n_i,
  bp_be_pipe_ctl_pipelined_if.slave     io
);

  logic                     ctl_v;
  logic                     btaken;
  logic [vaddr_width_p-1:0] npc;
  logic [vaddr_width_p-1:0] ntaken_tgt;
  bp_be_ctl_stage_s         in_s;
  bp_be_ctl_stage_s         last;
  logic                     br_v;
  logic                     mispredict;
  logic [cnt_width_p-1:0]   cnt_d, cnt_q;

  bp_be_ctl_resolve #(
    .vaddr_width_p (vaddr_width_p),
    .dword_width_p (dword_width_p)
  ) u_resolve (
    .fu_op_i      (io.fu_op_i),
    .baddr_sel_i  (io.baddr_sel_i),
    .pc_i         (io.pc_i),
    .rs1_i        (io.rs1_i),
    .rs2_i        (io.rs2_i),
    .imm_i        (io.imm_i),
    .ctl_v_o      (ctl_v),
    .btaken_o     (btaken),
    .npc_o        (npc),
    .ntaken_tgt_o (ntaken_tgt)
  );

  always_comb begin
    in_s            = '0;
    in_s.v          = io.v_i;
    in_s.queue_v    = io.v_i & io.queue_v_i;
    in_s.ctl_v      = ctl_v;
    in_s.btaken     = btaken;
    in_s.npc        = npc;
    in_s.ntaken_tgt = ntaken_tgt;
    in_s.pred_npc   = io.pred_npc_i;
  end

  for (genvar i = 0; i < latency_p; i++) begin : g_stg
    bp_be_ctl_stage_s src;
    bp_be_ctl_stage_s stage_d;
    bp_be_ctl_stage_s stage_q;

    if (i == 0) begin : g_head
      assign src = in_s;
    end else begin : g_body
      assign src = g_stg[i-1].stage_q;
    end

    always_comb begin
      stage_d = src;
      if (io.flush_i) begin
        stage_d.v       = 1'b0;
        stage_d.queue_v = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) stage_q <= '0;
      else            stage_q <= stage_d;
    end
  end

  assign last = g_stg[latency_p-1].stage_q;

  // A flush also squashes whatever is leaving the last stage this cycle.
  assign br_v       = last.v & last.queue_v & ~io.flush_i;
  assign mispredict = br_v & (last.npc != last.pred_npc);

  assign io.v_o          = last.v & last.ctl_v & ~io.flush_i;
  assign io.br_v_o       = br_v;
  assign io.btaken_o     = br_v & last.btaken;
  assign io.npc_o        = last.npc;
  assign io.mispredict_o = mispredict;
  assign io.data_o       = {{(dpath_width_p-vaddr_width_p){last.ntaken_tgt[vaddr_width_p-1]}},
                            last.ntaken_tgt};

  always_comb begin
    cnt_d = cnt_q;
    if (io.clr_cnt_i)                   cnt_d = '0;
    else if (mispredict && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign io.mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_bp_be_pipe_ctl_pipelined.sv
// tb_bp_be_pipe_ctl_pipelined: directed + random stimulus against a
// queue-based reference of the control pipe.
module tb_bp_be_pipe_ctl_pipelined;
  import bp_be_pkg::*;

  localparam int VA  = 39;
  localparam int DW  = 64;
  localparam int DP  = 66;
  localparam int LAT = 2;
  localparam int CW  = 16;
  localparam logic [63:0] MASK = (64'd1 << VA) - 64'd1;

  typedef struct {
    int            due;
    logic          ctl;
    logic          qv;
    logic          tk;
    logic [VA-1:0] npc;
    logic [VA-1:0] ntk;
    logic [VA-1:0] pred;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_pipe_ctl_pipelined_if #(
    .vaddr_width_p (VA),
    .dword_width_p (DW),
    .dpath_width_p (DP),
    .cnt_width_p   (CW)
  ) io ();

  bp_be_pipe_ctl_pipelined #(
    .vaddr_width_p (VA),
    .dword_width_p (DW),
    .dpath_width_p (DP),
    .latency_p     (LAT),
    .cnt_width_p   (CW)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (io)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  exp_t          q[$];
  exp_t          pend;
  logic          pend_v  = 1'b0;
  logic [CW-1:0] m_cnt   = '0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DP-1:0] sext(input logic [VA-1:0] a);
    return {{(DP-VA){a[VA-1]}}, a};
  endfunction

  function automatic exp_t ref_op(input logic qv, input logic [3:0] op,
                                  input logic bsel, input logic [VA-1:0] pc,
                                  input logic [63:0] rs1, input logic [63:0] rs2,
                                  input logic [63:0] imm, input logic [VA-1:0] pred);
    exp_t        e;
    logic [63:0] base, tgt, nt;
    e.due  = 0;
    e.qv   = qv;
    e.pred = pred;
    e.ctl  = 1'b1;
    case (op)
      e_ctrl_op_beq:  e.tk = (rs1 == rs2);
      e_ctrl_op_bne:  e.tk = (rs1 != rs2);
      e_ctrl_op_blt:  e.tk = ($signed(rs1) < $signed(rs2));
      e_ctrl_op_bge:  e.tk = ($signed(rs1) >= $signed(rs2));
      e_ctrl_op_bltu: e.tk = (rs1 < rs2);
      e_ctrl_op_bgeu: e.tk = (rs1 >= rs2);
      e_ctrl_op_jalr: e.tk = 1'b1;
      e_ctrl_op_jal:  e.tk = 1'b1;
      default: begin e.tk = 1'b0; e.ctl = 1'b0; end
    endcase
    base   = bsel ? rs1 : 64'(pc);
    tgt    = (base + imm) & MASK & ~64'd1;
    nt     = (64'(pc) + 64'd4) & MASK;
    e.ntk  = nt[VA-1:0];
    e.npc  = e.tk ? tgt[VA-1:0] : nt[VA-1:0];
    return e;
  endfunction

  task automatic set_op(input logic qv, input logic [3:0] op, input logic bsel,
                        input logic [VA-1:0] pc, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [63:0] imm,
                        input logic [VA-1:0] pred);
    io.v_i         = 1'b1;
    io.queue_v_i   = qv;
    io.fu_op_i     = bp_be_ctrl_fu_op_e'(op);
    io.baddr_sel_i = bsel;
    io.pc_i        = pc;
    io.rs1_i       = rs1;
    io.rs2_i       = rs2;
    io.imm_i       = imm;
    io.pred_npc_i  = pred;
    pend   = ref_op(qv, op, bsel, pc, rs1, rs2, imm, pred);
    pend_v = 1'b1;
  endtask

  // One clock: inputs for cycle cyc are already driven at posedge+1.
  task automatic tick(input logic fl, input logic clr);
    exp_t e;
    logic has, ev, ebr, etk, emp;
    io.flush_i   = fl;
    io.clr_cnt_i = clr;
    has = (q.size() > 0) && (q[0].due == cyc);
    ev = 0; ebr = 0; etk = 0; emp = 0;
    if (has) begin
      e   = q.pop_front();
      ev  = e.ctl & ~fl;
      ebr = e.qv & ~fl;
      etk = ebr & e.tk;
      emp = ebr & (e.npc != e.pred);
    end
    @(negedge clk);
    chk("v_o",     io.v_o, ev);
    chk("br_v_o",  io.br_v_o, ebr);
    chk("btaken",  io.btaken_o, etk);
    chk("mispred", io.mispredict_o, emp);
    chk("cnt",     io.mispredict_cnt_o, m_cnt);
    if (has) begin
      chk("npc",  io.npc_o, e.npc);
      chk("data", io.data_o, sext(e.ntk));
    end
    if (fl) q.delete();
    else if (pend_v) begin
      pend.due = cyc + LAT;
      q.push_back(pend);
    end
    if (clr) m_cnt = '0;
    else if (emp && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    io.v_i       = 1'b0;
    io.flush_i   = 1'b0;
    io.clr_cnt_i = 1'b0;
    pend_v       = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic bsel,
                        input logic [VA-1:0] pc, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [63:0] imm,
                        input logic [VA-1:0] pred);
    set_op(1'b1, op, bsel, pc, rs1, rs2, imm, pred);
    tick(1'b0, 1'b0);
    repeat (LAT - 1) tick(1'b0, 1'b0);
  endtask

  task automatic rand_op();
    logic [63:0] r1, r2, r3, imm;
    logic [11:0] i12;
    logic [3:0]  op;
    logic        bsel, qv;
    logic [VA-1:0] pc, pred;
    exp_t        e;
    r1  = {$urandom, $urandom};
    r3  = {$urandom, $urandom};
    case ($urandom % 4)
      0:       r2 = r1;
      1:       r2 = r1 ^ 64'h8000_0000_0000_0000;
      default: r2 = {$urandom, $urandom};
    endcase
    i12  = 12'($urandom);
    imm  = {{52{i12[11]}}, i12};
    op   = 4'($urandom % 10);
    bsel = 1'($urandom);
    qv   = ($urandom % 4) != 0;
    pc   = r3[VA-1:0];
    e    = ref_op(qv, op, bsel, pc, r1, r2, imm, '0);
    pred = ($urandom % 2 == 0) ? e.npc : VA'({$urandom, $urandom});
    set_op(qv, op, bsel, pc, r1, r2, imm, pred);
  endtask

  initial begin
    io.v_i = 0; io.queue_v_i = 0; io.fu_op_i = e_ctrl_op_beq;
    io.baddr_sel_i = 0; io.pc_i = '0; io.rs1_i = '0; io.rs2_i = '0;
    io.imm_i = '0; io.pred_npc_i = '0; io.flush_i = 0; io.clr_cnt_i = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_v",    io.v_o, 0);
    chk("rst_brv",  io.br_v_o, 0);
    chk("rst_tk",   io.btaken_o, 0);
    chk("rst_misp", io.mispredict_o, 0);
    chk("rst_npc",  io.npc_o, 0);
    chk("rst_data", io.data_o, 0);
    chk("rst_cnt",  io.mispredict_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(e_ctrl_op_beq, 0, 39'h1000, 64'd5, 64'd5, 64'h40, 39'h1040);
    chk("t1_brv", io.br_v_o, 1);
    chk("t1_tk",  io.btaken_o, 1);
    chk("t1_npc", io.npc_o, 39'h1040);
    chk("t1_mp",  io.mispredict_o, 0);

    run_op(e_ctrl_op_bltu, 0, 39'h3000, 64'd1, '1, 64'h100, 39'h3004);
    chk("t2_bltu_tk",  io.btaken_o, 1);
    chk("t2_bltu_npc", io.npc_o, 39'h3100);
    chk("t2_cnt0",     io.mispredict_cnt_o, 0);
    run_op(e_ctrl_op_blt, 0, 39'h3000, 64'd1, '1, 64'h100, 39'h3004);
    chk("t2_blt_tk",  io.btaken_o, 0);
    chk("t2_blt_npc", io.npc_o, 39'h3004);
    chk("t2_cnt1",    io.mispredict_cnt_o, 1);

    run_op(e_ctrl_op_jalr, 1, 39'h5000, 64'h2003, 64'd0, 64'd0, 39'h2000);
    chk("t3_npc",  io.npc_o, 39'h2002);
    chk("t3_mp",   io.mispredict_o, 1);
    chk("t3_v",    io.v_o, 1);
    chk("t3_data", io.data_o, 66'h5004);
    tick(0, 0);
    chk("t3_cnt",  io.mispredict_cnt_o, 2);

    set_op(1, e_ctrl_op_jal, 0, 39'h100, 0, 0, 64'h20, 39'h120);
    tick(0, 0);
    set_op(1, e_ctrl_op_beq, 0, 39'h200, 1, 1, 64'h20, 39'h220);
    tick(0, 0);
    set_op(1, e_ctrl_op_bne, 0, 39'h300, 1, 2, 64'h20, 39'h320);
    tick(1, 0);
    run_op(e_ctrl_op_jal, 0, 39'h400, 0, 0, 64'h40, 39'h440);
    chk("t4_brv", io.br_v_o, 1);
    chk("t4_npc", io.npc_o, 39'h440);

    run_op(e_ctrl_op_beq, 0, 39'h7F_FFFF_FFFC, 1, 2, 64'h40, 39'h0);
    chk("t5_npc",  io.npc_o, 39'h0);
    chk("t5_data", io.data_o, 66'h0);
    chk("t5_tk",   io.btaken_o, 0);
    run_op(e_ctrl_op_jal, 0, 39'h7F_FFFF_FFF0, 0, 0, 64'h0, 39'h7F_FFFF_FFF0);
    chk("t5_sext", io.data_o, 66'h3_FFFF_FFFF_FFFF_FFF4);
    chk("t5_brv",  io.br_v_o, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 4 != 0) rand_op();
      tick(($urandom % 16) == 0, ($urandom % 64) == 0);
    end
    repeat (LAT) tick(0, 0);

    for (int i = 0; i < (1 << CW) + 3; i++) begin
      set_op(1, e_ctrl_op_jal, 0, 39'h0, 0, 0, 64'h8, 39'h0);
      tick(0, 0);
    end
    repeat (2) begin
      set_op(1, e_ctrl_op_jal, 0, 39'h0, 0, 0, 64'h8, 39'h0);
      tick(0, 0);
    end
    chk("t6_sat",   io.mispredict_cnt_o, 16'hFFFF);
    chk("t6_mp_on", io.mispredict_o, 1);
    set_op(1, e_ctrl_op_jal, 0, 39'h0, 0, 0, 64'h8, 39'h0);
    tick(0, 1);
    chk("t6_clr",   io.mispredict_cnt_o, 0);

    set_op(1, e_ctrl_op_jal, 0, 39'h0, 0, 0, 64'h8, 39'h0);
    tick(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v",    io.v_o, 0);
    chk("t6_rst_brv",  io.br_v_o, 0);
    chk("t6_rst_mp",   io.mispredict_o, 0);
    chk("t6_rst_npc",  io.npc_o, 0);
    chk("t6_rst_data", io.data_o, 0);
    chk("t6_rst_cnt",  io.mispredict_cnt_o, 0);
    q.delete();
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 10;

    for (int i = 0; i < 200; i++) begin
      if ($urandom % 2 != 0) rand_op();
      tick(($urandom % 32) == 0, 0);
    end
    repeat (LAT) tick(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
